// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider.
//
// Retires one quotient bit per clock. A WIDTH-bit dividend/divisor pair is
// accepted over a valid/ready handshake, and a WIDTH-bit quotient and
// remainder are returned over a second valid/ready handshake.
//
// Optional build macro: DIV_SIGNED_EN
//   When defined, the port signed_op is added. It is sampled at acceptance
//   and selects two's-complement truncating division. The sign fix-up costs
//   one extra CALC cycle.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous, active-high reset
//   in_valid     operands presented
//   in_ready     divider idle, can accept an operation
//   dividend     numerator
//   divisor      denominator
//   signed_op    (DIV_SIGNED_EN only) treat operands as two's complement
//   out_valid    result valid
//   out_ready    consumer accepts result
//   quotient     dividend / divisor
//   remainder    dividend mod divisor
//   div_by_zero  divisor was zero for this result
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CW-1:0]    cnt_q;
  logic             dbz_q;
  logic             calc_end;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and try subtracting the divisor. Because rem_q < dvsr_q holds
  // between steps (or the divisor is zero), the true difference always fits
  // in WIDTH+1 signed bits, so the MSB is a reliable sign.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             trial_neg;

  assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_sh - {1'b0, dvsr_q};
  assign trial_neg = trial[WIDTH];

`ifdef DIV_SIGNED_EN
  logic fix_q;   // sign fix-up still pending after the magnitude steps
  logic qneg_q;  // quotient must be negated
  logic rneg_q;  // remainder takes the (negative) dividend sign
  logic fix_now;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    return (sgn && v[WIDTH-1]) ? negate(v) : v;
  endfunction

  // Counter reaches zero after the WIDTH magnitude steps; the fix-up then
  // runs as one more CALC cycle.
  assign fix_now  = fix_q && (cnt_q == '0);
  assign calc_end = fix_now || (!fix_q && (cnt_q == CW'(1)));
`else
  assign calc_end = (cnt_q == CW'(1));
`endif

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (calc_end)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath: capture at accept, one step per CALC cycle, hold in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      dbz_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      fix_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rem_q  <= '0;
            cnt_q  <= CW'(WIDTH);
            dbz_q  <= (divisor == '0);
`ifdef DIV_SIGNED_EN
            quo_q  <= magnitude(dividend, signed_op);
            dvsr_q <= magnitude(divisor, signed_op);
            fix_q  <= signed_op;
            qneg_q <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_q <= signed_op && dividend[WIDTH-1];
`else
            quo_q  <= dividend;
            dvsr_q <= divisor;
`endif
          end
        end
        CALC: begin
`ifdef DIV_SIGNED_EN
          if (fix_now) begin
            // A zero divisor keeps the all-ones quotient; negating the
            // remainder magnitude restores the original dividend.
            if (qneg_q && !dbz_q) quo_q <= negate(quo_q);
            if (rneg_q)           rem_q <= negate(rem_q);
            fix_q <= 1'b0;
          end else
`endif
          begin
            cnt_q <= cnt_q - CW'(1);
            quo_q <= {quo_q[WIDTH-2:0], ~trial_neg};
            rem_q <= trial_neg ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          end
        end
        default: ;  // DONE: results held until handoff
      endcase
    end
  end

endmodule
